// File: rtl/spi_sub_burst.sv
// spi_sub_burst -- SPI subordinate (mode 0) bridging a SPI master onto the
// on-chip register bus, with auto-incrementing burst read and burst write.
// Everything runs on sclk; miso is the only falling-edge flop.
//
// Frame (MSB first): {op[1:0], addr[ADDR_W-1:0], payload[DATA_W-1:0]}
//   op 00 READ, 01 WRITE, 10 BURST_WRITE, 11 BURST_READ (payload[BURST_W-1:0] = N-1)
//
// Ports
//   sclk    in   SPI clock, the only clock of the block
//   rst_n   in   asynchronous active-low reset
//   cs_n    in   chip select, active low, sampled on rising sclk
//   mosi    in   serial data in, sampled on rising sclk
//   miso    out  serial data out, updated on falling sclk
//   r_en    out  register read strobe, one cycle per word
//   w_en    out  register write strobe, one cycle per word
//   addr    out  register address, valid while r_en|w_en
//   data_o  out  register write data, valid while w_en
//   data_i  in   register read data, sampled at the edge ending an r_en cycle
//   busy    out  high whenever the engine is not idle
//   abort   out  one-cycle pulse when cs_n cuts a transaction short
module spi_sub_burst #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              r_en,
    output logic              w_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy,
    output logic              abort
);

    localparam int FRAME_W = 2 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CMD  = 3'd1;
    localparam logic [2:0] EXEC = 3'd2;
    localparam logic [2:0] RESP = 3'd3;
    localparam logic [2:0] BWR  = 3'd4;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_BWRITE = 2'b10;
    localparam logic [1:0] OP_BREAD  = 2'b11;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FRAME_PRE  = CNT_W'(FRAME_W - 2);
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WORD_PRE   = CNT_W'(DATA_W - 2);

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] rx_sr;
    logic [FRAME_W-1:0] tx_sr;
    logic [1:0]         op_r;
    logic [BURST_W-1:0] words_left;
    logic               in_hdr;

    logic [FRAME_W-1:0] frame;
    logic [1:0]         frame_op;
    logic               seg_last;
    logic               seg_pre;
    logic               more_words;
    logic               resp_done;

    // Full command as it stands on the edge that samples its last bit.
    assign frame    = {rx_sr, mosi};
    assign frame_op = frame[FRAME_W-1 -: 2];

    // RESP is split into segments: the FRAME_W-bit header, then DATA_W-bit
    // burst words. The next word is fetched during the last bit of the
    // current segment so it can follow without a gap.
    assign seg_last   = in_hdr ? (bit_cnt == FRAME_LAST) : (bit_cnt == WORD_LAST);
    assign seg_pre    = in_hdr ? (bit_cnt == FRAME_PRE)  : (bit_cnt == WORD_PRE);
    assign more_words = (words_left != '0);
    assign resp_done  = seg_last && !more_words;

    always_comb begin
        state_nx = state;
        if (cs_n) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = CMD;
                CMD:     if (bit_cnt == FRAME_LAST) state_nx = EXEC;
                EXEC:    state_nx = (op_r == OP_BWRITE) ? BWR : RESP;
                RESP:    if (resp_done) state_nx = CMD;
                BWR:     state_nx = BWR;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            op_r       <= OP_READ;
            words_left <= '0;
            in_hdr     <= 1'b0;
            r_en       <= 1'b0;
            w_en       <= 1'b0;
            addr       <= '0;
            data_o     <= '0;
            busy       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            r_en  <= 1'b0;
            w_en  <= 1'b0;
            abort <= 1'b0;
            if (cs_n) begin
                bit_cnt    <= '0;
                words_left <= '0;
                in_hdr     <= 1'b0;
                // A command with no bits yet (just after a response) is not
                // a partial transaction, nor is a completed response.
                if ((state == CMD && bit_cnt != '0) ||
                    (state == RESP && !resp_done) ||
                    (state == BWR && bit_cnt != '0))
                    abort <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        rx_sr   <= {rx_sr[FRAME_W-3:0], mosi};
                        bit_cnt <= CNT_W'(1);
                    end
                    CMD: begin
                        if (bit_cnt == FRAME_LAST) begin
                            op_r    <= frame_op;
                            addr    <= frame[DATA_W +: ADDR_W];
                            bit_cnt <= '0;
                            if (frame_op == OP_WRITE || frame_op == OP_BWRITE) begin
                                w_en   <= 1'b1;
                                data_o <= frame[DATA_W-1:0];
                            end else begin
                                r_en <= 1'b1;
                            end
                            words_left <= (frame_op == OP_BREAD) ? frame[BURST_W-1:0] : '0;
                        end else begin
                            rx_sr   <= {rx_sr[FRAME_W-3:0], mosi};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    EXEC: begin
                        // data_o still holds the WRITE payload for the echo.
                        tx_sr   <= {op_r, addr, (op_r == OP_WRITE) ? data_o : data_i};
                        bit_cnt <= '0;
                        in_hdr  <= 1'b1;
                    end
                    RESP: begin
                        if (seg_last) begin
                            bit_cnt <= '0;
                            in_hdr  <= 1'b0;
                            if (more_words) begin
                                tx_sr      <= {data_i, {(FRAME_W-DATA_W){1'b0}}};
                                words_left <= words_left - 1'b1;
                            end
                        end else begin
                            tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (seg_pre && more_words) begin
                                r_en <= 1'b1;
                                addr <= addr + 1'b1;
                            end
                        end
                    end
                    BWR: begin
                        rx_sr <= {rx_sr[FRAME_W-3:0], mosi};
                        if (bit_cnt == WORD_LAST) begin
                            w_en    <= 1'b1;
                            addr    <= addr + 1'b1;
                            data_o  <= {rx_sr[DATA_W-2:0], mosi};
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Mode 0: present the next bit on the falling edge so the master samples
    // it on the following rising edge.
    always_ff @(negedge sclk or negedge rst_n) begin
        if (!rst_n)
            miso <= 1'b0;
        else
            miso <= (state == RESP) ? tx_sr[FRAME_W-1] : 1'b0;
    end

endmodule

// File: tb/tb_spi_sub_burst.sv
// tb_spi_sub_burst -- self-checking bench for spi_sub_burst (default sizes).
// A SPI master drives frames on falling sclk; a register-file model answers
// reads. Expected strobes and response words are queued when a command is
// driven and popped when the DUT produces them.
module tb_spi_sub_burst;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 4;
    localparam int FRAME_W = 2 + ADDR_W + DATA_W;

    logic              sclk;
    logic              rst_n;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              r_en;
    logic              w_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] data_i;
    logic              busy;
    logic              abort;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W+DATA_W-1:0] exp_wr[$];
    logic [ADDR_W-1:0]        exp_rd[$];
    logic [FRAME_W-1:0]       exp_resp[$];

    int n_cmp;
    int n_err;
    int abort_cnt;

    spi_sub_burst #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .BURST_W (BURST_W)
    ) dut (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso),
        .r_en   (r_en),
        .w_en   (w_en),
        .addr   (addr),
        .data_o (data_o),
        .data_i (data_i),
        .busy   (busy),
        .abort  (abort)
    );

    assign data_i = mem[addr];

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: every strobe must match the head of its queue.
    always @(posedge sclk) begin
        #1;
        if (abort) abort_cnt++;
        if (r_en && w_en) check("rw_excl", {r_en, w_en}, 2'b00);
        if (w_en) begin
            if (exp_wr.size() == 0) begin
                check("w_en_unexp", w_en, 1'b0);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_wr.pop_front();
                check("w_addr", addr, e[DATA_W +: ADDR_W]);
                check("w_data", data_o, e[DATA_W-1:0]);
            end
        end
        if (r_en) begin
            if (exp_rd.size() == 0) begin
                check("r_en_unexp", r_en, 1'b0);
            end else begin
                logic [ADDR_W-1:0] a;
                a = exp_rd.pop_front();
                check("r_addr", addr, a);
            end
        end
    end

    // Drive the top n bits of a width-bit value, MSB first, on falling edges.
    task automatic send_msb(input logic [63:0] v, input int width, input int n);
        for (int i = width - 1; i >= width - n; i--) begin
            @(negedge sclk);
            cs_n = 1'b0;
            mosi = v[i];
        end
    endtask

    // Let the last command bit be sampled and the EXEC cycle pass.
    task automatic skip_exec();
        repeat (2) @(posedge sclk);
    endtask

    task automatic recv_check(input int n, input string tag);
        logic [FRAME_W-1:0] got;
        logic [FRAME_W-1:0] e;
        got = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #1;
            got = {got[FRAME_W-2:0], miso};
        end
        if (exp_resp.size() == 0) begin
            check({tag, "_noexp"}, got, '0);
        end else begin
            e = exp_resp.pop_front();
            check(tag, got, e);
        end
    endtask

    task automatic end_cs();
        @(negedge sclk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge sclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_W-1:0] f;
        n_cmp     = 0;
        n_err     = 0;
        abort_cnt = 0;
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        for (int unsigned i = 0; i < (1 << ADDR_W); i++)
            mem[i] = 32'h5A00_0000 | i;
        mem[10'h034] = 32'hCAFEBABE;
        mem[10'h3FE] = 32'hDEADBEEF;
        mem[10'h3FF] = 32'h0BADF00D;
        mem[10'h000] = 32'h13579BDF;
        mem[10'h001] = 32'h2468ACE0;

        // Reset state
        #23;
        check("rst_miso", miso, 1'b0);
        check("rst_r_en", r_en, 1'b0);
        check("rst_w_en", w_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_abort", abort, 1'b0);
        check("rst_addr", addr, '0);
        check("rst_data_o", data_o, '0);
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        // 1: single WRITE, echoed payload
        f = {2'b01, 10'h035, 32'hCAFEBABE};
        exp_wr.push_back({10'h035, 32'hCAFEBABE});
        exp_resp.push_back(f);
        send_msb(64'(f), FRAME_W, FRAME_W);
        skip_exec();
        recv_check(FRAME_W, "wr_resp");
        end_cs();
        check("wr_abort", abort_cnt, 0);

        // 2: single READ
        f = {2'b00, 10'h034, 32'h0};
        exp_rd.push_back(10'h034);
        exp_resp.push_back({2'b00, 10'h034, 32'hCAFEBABE});
        send_msb(64'(f), FRAME_W, FRAME_W);
        skip_exec();
        recv_check(FRAME_W, "rd_resp");
        end_cs();

        // 3: BURST_READ of 4 words wrapping 3FE -> 001, no gaps between words
        f = {2'b11, 10'h3FE, 32'h0000_0003};
        exp_rd.push_back(10'h3FE);
        exp_rd.push_back(10'h3FF);
        exp_rd.push_back(10'h000);
        exp_rd.push_back(10'h001);
        exp_resp.push_back({2'b11, 10'h3FE, 32'hDEADBEEF});
        exp_resp.push_back(FRAME_W'(32'h0BADF00D));
        exp_resp.push_back(FRAME_W'(32'h13579BDF));
        exp_resp.push_back(FRAME_W'(32'h2468ACE0));
        send_msb(64'(f), FRAME_W, FRAME_W);
        skip_exec();
        recv_check(FRAME_W, "brd_hdr");
        recv_check(DATA_W, "brd_w1");
        recv_check(DATA_W, "brd_w2");
        recv_check(DATA_W, "brd_w3");
        end_cs();
        check("brd_rd_left", exp_rd.size(), 0);

        // 4: BURST_WRITE, cs_n rises 5 bits into the 4th word
        f = {2'b10, 10'h100, 32'h11111111};
        exp_wr.push_back({10'h100, 32'h11111111});
        exp_wr.push_back({10'h101, 32'h22222222});
        exp_wr.push_back({10'h102, 32'h33333333});
        send_msb(64'(f), FRAME_W, FRAME_W);
        @(negedge sclk);
        mosi = 1'b0;
        send_msb(64'(32'h22222222), DATA_W, DATA_W);
        send_msb(64'(32'h33333333), DATA_W, DATA_W);
        send_msb(64'(32'h44444444), DATA_W, 5);
        end_cs();
        check("bwr_abort", abort_cnt, 1);
        check("bwr_busy", busy, 1'b0);
        check("bwr_wr_left", exp_wr.size(), 0);

        // 5: cs_n rises after 20 command bits, then a normal WRITE
        f = {2'b01, 10'h2A5, 32'h12345678};
        send_msb(64'(f), FRAME_W, 20);
        end_cs();
        check("cmd_abort", abort_cnt, 2);
        check("cmd_busy", busy, 1'b0);
        exp_wr.push_back({10'h2A5, 32'h12345678});
        exp_resp.push_back(f);
        send_msb(64'(f), FRAME_W, FRAME_W);
        skip_exec();
        recv_check(FRAME_W, "wr2_resp");
        end_cs();

        // 6: reset while a READ response is on miso (7th bit is a 1)
        f = {2'b00, 10'h034, 32'h0};
        exp_rd.push_back(10'h034);
        send_msb(64'(f), FRAME_W, FRAME_W);
        skip_exec();
        repeat (6) @(posedge sclk);
        @(negedge sclk);
        #2;
        rst_n = 1'b0;
        cs_n  = 1'b1;
        #1;
        check("mrst_miso", miso, 1'b0);
        check("mrst_r_en", r_en, 1'b0);
        check("mrst_w_en", w_en, 1'b0);
        check("mrst_busy", busy, 1'b0);
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);
        exp_rd.push_back(10'h034);
        exp_resp.push_back({2'b00, 10'h034, 32'hCAFEBABE});
        send_msb(64'(f), FRAME_W, FRAME_W);
        skip_exec();
        recv_check(FRAME_W, "rd2_resp");
        end_cs();

        check("end_wr_left", exp_wr.size(), 0);
        check("end_rd_left", exp_rd.size(), 0);
        check("end_resp_left", exp_resp.size(), 0);
        check("end_abort", abort_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
